fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage of the single-cycle core. Owns the PC and drives the word address of the
//  64-word asynchronous instruction memory, which returns its word combinationally in the same cycle.
//  Fetched {pc, instr} pairs go into a small queue that feeds decode through a valid/ready handshake.
//  Supports a redirect (branch/jump) with flush, and a halt request.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value after reset; bits [1:0] must be 0
//  QDEPTH    2              fetch queue depth in entries; power of two, >= 2
//  IMEM_AW   6              instruction memory word-address width (64 words)
// PORTS
//  clk            in   1        single clock; all state updates on its rising edge
//  rst_n          in   1        reset, synchronous, active-low
//  imem_addr      out  IMEM_AW  word address to instr memory, = pc[IMEM_AW+1:2]
//  imem_data      in   32       instr memory read data, combinational from imem_addr
//  redirect_valid in   1        load redirect_pc into PC and flush the queue
//  redirect_pc    in   32       target byte address; bits [1:0] ignored (forced 0)
//  halt_req       in   1        stop fetching; level-sensitive, sampled every cycle
//  instr_valid    out  1        queue head holds a valid instruction
//  instr_ready    in   1        decode accepts the head this cycle
//  instr          out  32       instruction at the queue head
//  instr_pc       out  32       byte PC of instr
//  halted         out  1        in HALT state and queue empty
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): pc=RESET_PC, state=BOOT, queue empty.
//    Outputs: instr_valid=0, instr=0, instr_pc=0, halted=0, imem_addr=RESET_PC[IMEM_AW+1:2].
//  - FSM states:
//    BOOT : no fetch; goes to FETCH on the next cycle unconditionally.
//    FETCH: push when the queue can accept: count<QDEPTH, OR (count==QDEPTH AND a pop occurs this cycle).
//           A push stores {pc, imem_data} and advances pc by 4.
//           halt_req=1 -> HALT with no push that cycle.
//    HALT : no pushes; the queue still drains to decode. redirect_valid=1 -> FETCH.
//  - Pop: instr_valid & instr_ready. instr and instr_pc are driven from the head entry, not registered
//    again, so there is 0-cycle latency from the head to the outputs.
//  - Latency: a word addressed in cycle N appears at the head in cycle N+1 when the queue was empty.
//  - Redirect (highest priority, any state except BOOT):
//    pc <= {redirect_pc[31:2],2'b00}; queue flushed; no push that cycle; state <= FETCH.
//    A pop in the same cycle still counts as accepted by decode.
//    The first redirected instruction is valid 2 cycles after the redirect cycle.
//  - Redirect in BOOT is ignored.
//  - Simultaneous redirect_valid and halt_req: redirect wins; halt_req is re-evaluated next cycle.
//  - Wrap-around:
//    pc increments modulo 2^32.
//    imem_addr wraps modulo 2^IMEM_AW, so pc=0xFC fetches word 63 and pc=0x100 fetches word 0.
//    Queue pointers wrap modulo QDEPTH.
//  - halted = (state==HALT) & (count==0), registered-state derived with no combinational input path.
//  - Reset asserted mid-operation discards queue contents and in-flight redirects; same state as power-on reset.
//  - instr_valid never depends combinationally on instr_ready.
//  - Queue count width: $clog2(QDEPTH+1).
// STRUCTURE
//  - Package fetch_pkg:
//    XLEN=32; INSTR_ALIGN=2;
//    typedef enum logic[1:0] {BOOT, FETCH, HALT} fetch_state_t;
//    typedef struct packed {logic[31:0] pc; logic[31:0] instr;} fetch_entry_t.
//  - One sub-module, fetch_queue: synchronous FIFO of fetch_entry_t.
//    Parameter QDEPTH; ports push, pop, flush, full, empty, count, head.
//    flush overrides push/pop in the same cycle.
//  - Top level holds pc, the FSM, the push/pop/flush logic and the output muxing.
// TESTING (imem preloaded: w0=0x00FF0FF0, w1=0x12FC123A, w2=0xAA22CC33, w3=0x00880988, w45=0xBBBBBBBB)
//  1. Reset, release, instr_ready=1 -> instr_valid rises 2 cycles after release.
//     Decode sees (pc,instr) = (0,0x00FF0FF0), (4,0x12FC123A), (8,0xAA22CC33), (0xC,0x00880988) on consecutive cycles.
//  2. instr_ready=0 for 5 cycles -> queue fills at 2 entries; pc holds at 8; head stays 0x00FF0FF0.
//     Then instr_ready=1 -> in-order delivery, no loss or duplicates.
//  3. Redirect to 0xB6 while the queue holds 2 entries -> queue flushed (instr_valid=0 next cycle).
//     Next delivered entry is (0xB4,0xBBBBBBBB), since bits [1:0] are ignored.
//  4. halt_req=1 with 2 entries queued -> no new fetch; entries drain; halted=1 once empty.
//     Then redirect to 0x0 -> halted=0 and fetch resumes with 0x00FF0FF0.
//  5. Redirect to 0xFC, instr_ready=1 -> pcs 0xFC, 0x100, 0x104; imem_addr 63, 0, 1; instr 2nd = 0x00FF0FF0.
//  6. rst_n=0 for 1 cycle mid-stream with a full queue -> all outputs at reset values next cycle.
//     Fetch restarts from RESET_PC; redirect_valid held high during BOOT is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
// No logic, types and widths only.
// Not applicable: holds no flow-control state.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_ALIGN = 2;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: full is reported; the caller may push while full only with a pop in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 push_entry,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(QDEPTH+1)-1:0]  count,
    output fetch_entry_t                 head
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH+1);

    fetch_entry_t    mem [QDEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is only consumed when count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(QDEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads async imem, queues {pc, instr} for decode.
// Latency: word addressed in cycle N is at the queue head in cycle N+1 (queue empty).
// Backpressure: fetch stalls when the queue is full and decode does not pop that cycle.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2,
    parameter int          IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               halt_req,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    output logic               halted
);

    localparam int CW = $clog2(QDEPTH+1);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc;
    logic            redirect;
    logic            push;
    logic            pop;
    logic            q_full;
    logic            q_empty;
    logic [CW-1:0]   q_count;
    fetch_entry_t    q_head;
    fetch_entry_t    push_entry;

    assign redirect   = redirect_valid && (state != BOOT);
    assign pop        = !q_empty && instr_ready;
    assign push_entry = '{pc: pc, instr: imem_data};

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    state_nxt = FETCH;
                end else if (halt_req) begin
                    state_nxt = HALT;
                end else begin
                    push = !q_full || pop;
                end
            end
            HALT: begin
                if (redirect) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                pc <= redirect_pc & ~32'h3;
            end else if (push) begin
                pc <= pc + 32'd4;
            end
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect),
        .push_entry (push_entry),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count),
        .head       (q_head)
    );

    // Outputs read zero while empty so stale storage never leaks to decode.
    assign imem_addr   = pc[IMEM_AW+INSTR_ALIGN-1:INSTR_ALIGN];
    assign instr_valid = !q_empty;
    assign instr       = q_empty ? '0 : q_head.instr;
    assign instr_pc    = q_empty ? '0 : q_head.pc;
    assign halted      = (state == HALT) && q_empty;

endmodule
